// File: rtl/wide_add_sequencer_pkg.sv
// Shared constants for the wide-add sequencer and the adder it drives.
// Holds the FSM encoding and the default slice geometry and watchdog limit.
package wide_add_sequencer_pkg;

   localparam int DEF_N       = 8;
   localparam int DEF_WORDS   = 4;
   localparam int DEF_TIMEOUT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } seqState_t;

   // Slice index width, kept at least one bit so a single-slice build still elaborates.
   function automatic int idxWidth(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Requester-side and adder-side bundles of the wide-add sequencer.
// master drives the request (requester) or the issue (sequencer); slave is the other end.
interface wide_add_sequencer_if
   import wide_add_sequencer_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int WORDS = DEF_WORDS
);
   logic               iStart;
   logic               iCarryIn;
   logic [N*WORDS-1:0] iA;
   logic [N*WORDS-1:0] iB;
   logic               oBusy;
   logic               oDone;
   logic               oError;
   logic [N*WORDS-1:0] oSum;
   logic               oCarryOut;

   modport master (
      output iStart, iCarryIn, iA, iB,
      input  oBusy, oDone, oError, oSum, oCarryOut
   );

   modport slave (
      input  iStart, iCarryIn, iA, iB,
      output oBusy, oDone, oError, oSum, oCarryOut
   );
endinterface

interface wide_add_sequencer_add_if
   import wide_add_sequencer_pkg::*;
#(
   parameter int N = DEF_N
);
   logic         oAddValid;
   logic [N-1:0] oAddX;
   logic [N-1:0] oAddY;
   logic         oAddCarryIn;
   logic [N-1:0] iAddZ;
   logic         iAddCarryOut;
   logic         iAddReady;

   modport master (
      output oAddValid, oAddX, oAddY, oAddCarryIn,
      input  iAddZ, iAddCarryOut, iAddReady
   );

   modport slave (
      input  oAddValid, oAddX, oAddY, oAddCarryIn,
      output iAddZ, iAddCarryOut, iAddReady
   );
endinterface

// File: rtl/wide_add_sequencer_add_watchdog.sv
// Clearable cycle counter that flags when TIMEOUT-1 counted cycles have elapsed.
// Latency: oExpired is a compare on the registered count, valid the cycle it is reached.
// Backpressure: none; the counter saturates at the compare value until cleared.
module add_watchdog
   import wide_add_sequencer_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
)(
   input  logic clk,
   input  logic resetn,
   input  logic iClear,
   input  logic iCount,
   output logic oExpired
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (iClear) begin
         count <= '0;
      end else if (iCount && !oExpired) begin
         count <= count + 1'b1;
      end
   end

   assign oExpired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wide_add_sequencer.sv
// Adds two N*WORDS operands by walking N-bit slices LSB first through a shared adder.
// Latency: WORDS*(L+1)+1 cycles from iStart to oDone for an adder of latency L.
// Backpressure: none; iStart is dropped while oBusy, a stalled adder trips oError.
module wide_add_sequencer
   import wide_add_sequencer_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int WORDS   = DEF_WORDS,
   parameter int TIMEOUT = DEF_TIMEOUT
)(
   input logic                      clk,
   input logic                      resetn,
   wide_add_sequencer_if.slave      req,
   wide_add_sequencer_add_if.master add
);
   localparam int            IW       = idxWidth(WORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   seqState_t          state;
   logic [N*WORDS-1:0] opA;
   logic [N*WORDS-1:0] opB;
   logic [N*WORDS-1:0] sum;
   logic [IW-1:0]      idx;
   logic               carry;
   logic               error;
   logic               busy;
   logic               done;
   logic               addValid;
   logic               wdClear;
   logic               wdCount;
   logic               wdExpired;

   assign wdClear = (state == ISSUE);
   assign wdCount = (state == WAIT);

   add_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) uWatchdog (
      .clk     (clk),
      .resetn  (resetn),
      .iClear  (wdClear),
      .iCount  (wdCount),
      .oExpired(wdExpired)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         opA      <= '0;
         opB      <= '0;
         sum      <= '0;
         idx      <= '0;
         carry    <= 1'b0;
         error    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         addValid <= 1'b0;
      end else begin
         done     <= 1'b0;
         addValid <= 1'b0;
         case (state)
            IDLE: begin
               if (req.iStart) begin
                  opA      <= req.iA;
                  opB      <= req.iB;
                  carry    <= req.iCarryIn;
                  sum      <= '0;
                  idx      <= '0;
                  error    <= 1'b0;
                  busy     <= 1'b1;
                  addValid <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               // A result arriving on the timeout cycle still counts.
               if (add.iAddReady) begin
                  sum[int'(idx)*N +: N] <= add.iAddZ;
                  carry                 <= add.iAddCarryOut;
                  if (idx == LAST_IDX) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     idx      <= idx + 1'b1;
                     addValid <= 1'b1;
                     state    <= ISSUE;
                  end
               end else if (wdExpired) begin
                  error <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign req.oBusy     = busy;
   assign req.oDone     = done;
   assign req.oError    = error;
   assign req.oSum      = sum;
   assign req.oCarryOut = carry;

   assign add.oAddValid   = addValid;
   assign add.oAddX       = opA[int'(idx)*N +: N];
   assign add.oAddY       = opB[int'(idx)*N +: N];
   assign add.oAddCarryIn = carry;

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Sequences a multi-word addition through the shared N-bit pipelined Brent-Kung adder, one slice at a time, from LSB to MSB.
- Carry-out of each slice is chained into the carry-in of the next slice.
- Sits between a requesting master (start/done handshake) and the adder's valid/ready interface.
- Adds a watchdog that flags a stalled adder.

Parameters:
N, 8, slice width; must match the adder width
WORDS, 4, number of slices; total operand width is N*WORDS
TIMEOUT, 8, max cycles in WAIT before iAddReady is declared lost

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
iStart  in  1  start request; sampled only in IDLE
iCarryIn  in  1  carry into slice 0
iA  in  N*WORDS  operand A
iB  in  N*WORDS  operand B
oBusy  out  1  high in every state except IDLE
oDone  out  1  one-cycle completion pulse
oError  out  1  sticky timeout flag
oSum  out  N*WORDS  result
oCarryOut  out  1  carry out of slice WORDS-1
oAddValid  out  1  issue strobe to the adder
oAddX  out  N  slice of A at index idx
oAddY  out  N  slice of B at index idx
oAddCarryIn  out  1  chained carry
iAddZ  in  N  adder sum
iAddCarryOut  in  1  adder carry-out
iAddReady  in  1  adder result valid

Behaviour:
- Interface: one clock, clk. Reset resetn is asynchronous, active-low, and clears every register.
- Reset values: all outputs 0 and FSM in IDLE.
- Registers: opA, opB, carry, idx (clog2(WORDS) bits), sum, wdog counter, error.
- FSM states are IDLE, ISSUE, WAIT and DONE.
- IDLE:
  - On iStart, capture iA→opA, iB→opB, iCarryIn→carry, clear idx, clear error, then go to ISSUE.
  - With no iStart, stay in IDLE.
- ISSUE:
  - oAddValid=1 for exactly this one cycle.
  - Clear wdog, then go to WAIT.
- WAIT:
  - wdog increments each cycle.
  - On iAddReady: sum[idx*N +: N]<=iAddZ and carry<=iAddCarryOut.
    - If idx==WORDS-1, go to DONE.
    - Otherwise idx++ and go to ISSUE.
  - If wdog reaches TIMEOUT-1 without iAddReady: set error, go to DONE, leave remaining sum slices unchanged.
  - If iAddReady and the timeout coincide, iAddReady wins.
- DONE:
  - oDone=1 for one cycle, then go to IDLE.
- Adder outputs:
  - oAddX, oAddY and oAddCarryIn are combinational from opA/opB slice idx and carry.
  - They are meaningful only while oAddValid=1.
- Result outputs:
  - oSum = sum register; oCarryOut = carry register.
  - Both hold stable from oDone until the next accepted iStart.
  - oSum is cleared on start capture.
- oError holds until the next accepted iStart.
- iStart is ignored in ISSUE, WAIT and DONE. No queuing, no back-pressure; oBusy is the master's accept indicator.
- iAddReady outside WAIT is ignored. It is never counted as a result for a later slice.
- Latency: with adder latency L (valid→ready):
  - slice k issues at cycle 1+k(L+1) after the iStart cycle 0;
  - oDone is high at cycle WORDS*(L+1)+1.
  - For WORDS=4, L=2: oDone at cycle 13.
- No overflow handling beyond oCarryOut; arithmetic is unsigned modulo 2^(N*WORDS).
- resetn mid-operation aborts immediately to IDLE with outputs 0. No oDone is generated for the aborted operation.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3);
  - default N, WORDS and TIMEOUT constants shared with the adder instantiation.
- One natural sub-module: add_watchdog.
  - Clearable counter with a TIMEOUT-reached compare.
  - Ports clk, resetn, iClear, iCount, oExpired.
- Registers use the team's asynchronous-reset D flip-flop cell.

Test Plan:
- A=0x000000FF, B=0x00000001, Cin=0, adder model L=2 → oSum=0x00000100, oCarryOut=0, oDone at cycle 13, exactly 4 oAddValid pulses with oAddCarryIn=0,1,0,0.
- A=0xFFFFFFFF, B=0x00000000, Cin=1 → oSum=0x00000000, oCarryOut=1, oError=0.
- A=0x12345678, B=0x9ABCDEF0, Cin=0 → oSum=0xACF13568, oCarryOut=0; the oAddCarryIn sequence is 0,1,1,0.
- iStart with A=1,B=1, then iStart with A=5,B=5 at cycle 4 → second ignored; oSum=0x00000002, single oDone.
- Adder model never returns iAddReady on slice 1 → oError=1 and oDone pulse TIMEOUT cycles after WAIT entry, then IDLE. Next iStart clears oError and completes correctly.
- resetn low at cycle 6 mid-operation → all outputs 0 asynchronously, no oDone. After release, A=3,B=4 gives oSum=7.
